// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: sets byte enables and lane-replicated store data, sign- or
// zero-extends loads, and stalls the pipeline until the bus acks or the timeout fires.
module lsu_mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  mem_acc_mode_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misaligned_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    mode_q, mode_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          access, is_byte, is_half, is_mis;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new, lane, load_ext;

    // Unused funct3 codes (011, 110, 111) fall through to the word case.
    assign access  = rd_en_i | wr_en_i;
    assign is_byte = (mem_acc_mode_i[1:0] == 2'b00);
    assign is_half = (mem_acc_mode_i[1:0] == 2'b01);
    assign is_mis  = (is_half & addr_i[0]) | (~is_byte & ~is_half & (addr_i[1:0] != 2'b00));

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = wdata_i;
        if (is_byte) begin
            wdata_new = {4{wdata_i[7:0]}};
            if (wr_en_i) be_new = 4'b0001 << addr_i[1:0];
        end else if (is_half) begin
            wdata_new = {2{wdata_i[15:0]}};
            if (wr_en_i) be_new = addr_i[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Loads read the whole word; shift the addressed lane down, then extend.
    assign lane = bus_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_ext = bus_rdata_i;
        if (mode_q[1:0] == 2'b00)
            load_ext = {{24{lane[7] & ~mode_q[2]}}, lane[7:0]};
        else if (mode_q[1:0] == 2'b01)
            load_ext = {{16{lane[15] & ~mode_q[2]}}, lane[15:0]};
    end

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        mode_d        = mode_q;
        off_d         = off_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        stall_o       = 1'b0;
        misaligned_o  = 1'b0;
        rdata_valid_o = 1'b0;
        bus_err_o     = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (access && is_mis) begin
                        misaligned_o = 1'b1;
                    end else if (access) begin
                        stall_o   = 1'b1;
                        state_d   = REQ;
                        bus_req_d = 1'b1;
                        we_d      = wr_en_i;
                        addr_d    = {addr_i[31:2], 2'b00};
                        be_d      = be_new;
                        wdata_d   = wdata_new;
                        mode_d    = mem_acc_mode_i;
                        off_d     = addr_i[1:0];
                        err_d     = 1'b0;
                        cnt_d     = '0;
                    end
                end
                REQ: begin
                    stall_o = 1'b1;
                    if (bus_ack_i) begin
                        if (!we_q) rdata_d = load_ext;
                        bus_req_d = 1'b0;
                        state_d   = DONE;
                    end else if (TIMEOUT > 0 && cnt_q == CNT_LAST) begin
                        bus_req_d = 1'b0;
                        err_d     = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    rdata_valid_o = ~we_q;
                    bus_err_o     = err_q;
                    state_d       = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            mode_q    <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            mode_q    <= mode_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
endmodule
